fma_mul_server: RTL and testbench
=================================

Name: fma_mul_server

Overview:
Responder end of the multiplier request interface that FMA/FMUL pipelines drive. Serves two requester ports through one shared pipelined unsigned 27x27 multiplier with round-robin arbitration. Returns a 54-bit product at fixed latency, tagged to the granted port. Lets two FP pipelines share a single multiplier array.

Parameters:
W, 27, operand width in bits (product is 2*W).
LAT, 2, cycles from grant to response; legal values 1 or 2.
CNTW, 16, width of the saturating grant counters.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  2  per-port request valid; bit k = port k
req_ready  out  2  per-port grant (combinational from req_valid and rr_ptr)
req_a0  in  W  port 0 multiplicand
req_b0  in  W  port 0 multiplier
req_a1  in  W  port 1 multiplicand
req_b1  in  W  port 1 multiplier
rsp_valid  out  2  one-hot response strobe; bit k = result for port k
rsp_out  out  2*W  product
busy  out  1  any operation in flight
gnt_cnt0  out  CNTW  saturating count of port-0 grants
gnt_cnt1  out  CNTW  saturating count of port-1 grants

Behaviour:
- Reset (async, active-high) values:
  - rsp_valid=0, rsp_out=0, busy=0, gnt_cnt0=gnt_cnt1=0, rr_ptr=0 (port 0 preferred), all pipeline valid bits=0.
  - In-flight operations are discarded. No response appears after reset deassertion for a request accepted before reset.
- Arbitration:
  - At most one grant per cycle. req_ready is one-hot or zero.
  - Only one port valid: that port is granted.
  - Both ports valid: port rr_ptr is granted.
  - After any grant to port k, rr_ptr <= ~k. With no grant, rr_ptr holds.
  - A request transfers when req_valid[k] & req_ready[k]. Operands are sampled that cycle.
  - A requester may hold req_valid high across cycles. Every granted cycle is a new operation.
- Pipeline, no backpressure, fully pipelined (one new op per cycle):
  - LAT=1: product a*b is registered at grant. rsp_valid[k] asserts on the next cycle.
  - LAT=2, stage 1: split a=aH:aL and b=bH:bL with low halves of 14 bits. Register the four partial products aL*bL, aL*bH, aH*bL, aH*bH, plus the port tag.
  - LAT=2, stage 2: shift-align and sum the partial products into rsp_out. rsp_valid asserts at grant+2.
  - Arithmetic is unsigned. The full 2*W result never overflows. 0*x=0.
- Response:
  - rsp_valid is a single-cycle pulse per accepted op, in grant order.
  - rsp_out holds its last value when rsp_valid=0.
  - Back-to-back grants give back-to-back responses, each tagged correctly.
- busy = OR of all pipeline-stage valid bits. It deasserts the cycle after the last rsp_valid pulse.
- gnt_cntk increments on each port-k grant and saturates at all-ones, with no wrap.
- Simultaneous events:
  - A grant in the same cycle as a response is independent; both occur.
  - A counter at saturation stays at all-ones while grants continue.
- Illegal LAT values give an elaboration error.

Test Plan:
- Reset, then port0 valid with a=0x800000, b=0x800000 for 1 cycle (LAT=2) -> req_ready=01 that cycle; rsp_valid=01 two cycles later with rsp_out=0x400000000000; busy high for exactly 2 cycles.
- Port1 only with a=0xFFFFFF, b=0xFFFFFF -> rsp_valid=10, rsp_out=0xFFFFFE000001 at grant+LAT; gnt_cnt1=1.
- Both ports valid continuously for 6 cycles from reset -> grants alternate 01,10,01,10,01,10; responses appear in the same order, each matching its port's operands; gnt_cnt0=gnt_cnt1=3.
- Port0 a=0x7FFFFFF (full 27-bit), b=0x7FFFFFF -> rsp_out=0x3FFFFFF0000001; port0 a=0, b=0x123456 -> rsp_out=0.
- Assert reset while 2 ops are in flight -> all outputs 0 immediately (asynchronously, no clock edge needed); no rsp_valid after release; rr_ptr back to port 0 (next contention grants port 0).
- Force gnt_cnt0 to 0xFFFE, then make 3 port-0 grants -> gnt_cnt0 reads 0xFFFF, 0xFFFF, 0xFFFF.

Source files
------------

// File: rtl/fma_mul_server.sv
// Two-port round-robin front end for one shared pipelined unsigned WxW multiplier.
// Fixed-latency responses (LAT 1 or 2) are tagged with the port that was granted.
module fma_mul_server #(
   parameter int W    = 27,
   parameter int LAT  = 2,
   parameter int CNTW = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [W-1:0]      req_a0,
   input  logic [W-1:0]      req_b0,
   input  logic [W-1:0]      req_a1,
   input  logic [W-1:0]      req_b1,
   output logic [1:0]        rsp_valid,
   output logic [2*W-1:0]    rsp_out,
   output logic              busy,
   output logic [CNTW-1:0]   gnt_cnt0,
   output logic [CNTW-1:0]   gnt_cnt1
);

   localparam int PW = 2 * W;

   logic            r_rr;
   logic [1:0]      w_gnt;
   logic            w_any;
   logic            w_tag;
   logic [W-1:0]    w_a;
   logic [W-1:0]    w_b;
   logic [CNTW-1:0] r_cnt0;
   logic [CNTW-1:0] r_cnt1;
   logic            r_ov;
   logic            r_otag;
   logic [PW-1:0]   r_out;

   if (LAT != 1 && LAT != 2) begin : g_bad_lat
      $error("fma_mul_server: LAT must be 1 or 2");
   end

   always_comb begin
      w_gnt = 2'b00;
      unique case (req_valid)
         2'b01:   w_gnt = 2'b01;
         2'b10:   w_gnt = 2'b10;
         2'b11:   w_gnt = r_rr ? 2'b10 : 2'b01;
         default: w_gnt = 2'b00;
      endcase
   end

   assign w_any     = |w_gnt;
   assign w_tag     = w_gnt[1];
   assign w_a       = w_tag ? req_a1 : req_a0;
   assign w_b       = w_tag ? req_b1 : req_b0;
   assign req_ready = w_gnt;

   // Pointer names the port preferred on the next contended cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rr   <= 1'b0;
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else begin
         if (w_any)
            r_rr <= ~w_tag;
         if (w_gnt[0] && !(&r_cnt0))
            r_cnt0 <= r_cnt0 + 1'b1;
         if (w_gnt[1] && !(&r_cnt1))
            r_cnt1 <= r_cnt1 + 1'b1;
      end
   end

   if (LAT == 1) begin : g_lat1
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_ov   <= 1'b0;
            r_otag <= 1'b0;
            r_out  <= '0;
         end else begin
            r_ov <= w_any;
            if (w_any) begin
               r_otag <= w_tag;
               r_out  <= PW'(w_a) * PW'(w_b);
            end
         end
      end
      assign busy = r_ov;
   end else begin : g_lat2
      localparam int L = 14;
      localparam int H = W - L;

      logic [L-1:0]   w_al;
      logic [L-1:0]   w_bl;
      logic [H-1:0]   w_ah;
      logic [H-1:0]   w_bh;
      logic           r_s1_v;
      logic           r_s1_tag;
      logic [2*L-1:0] r_ll;
      logic [L+H-1:0] r_lh;
      logic [L+H-1:0] r_hl;
      logic [2*H-1:0] r_hh;
      logic [PW-1:0]  w_sum;

      assign w_al = w_a[L-1:0];
      assign w_ah = w_a[W-1:L];
      assign w_bl = w_b[L-1:0];
      assign w_bh = w_b[W-1:L];

      assign w_sum = (PW'(r_hh) << (2 * L))
                   + ((PW'(r_lh) + PW'(r_hl)) << L)
                   + PW'(r_ll);

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_s1_v   <= 1'b0;
            r_s1_tag <= 1'b0;
            r_ll     <= '0;
            r_lh     <= '0;
            r_hl     <= '0;
            r_hh     <= '0;
            r_ov     <= 1'b0;
            r_otag   <= 1'b0;
            r_out    <= '0;
         end else begin
            r_s1_v <= w_any;
            if (w_any) begin
               r_s1_tag <= w_tag;
               r_ll     <= (2*L)'(w_al) * (2*L)'(w_bl);
               r_lh     <= (L+H)'(w_al) * (L+H)'(w_bh);
               r_hl     <= (L+H)'(w_ah) * (L+H)'(w_bl);
               r_hh     <= (2*H)'(w_ah) * (2*H)'(w_bh);
            end
            r_ov <= r_s1_v;
            if (r_s1_v) begin
               r_otag <= r_s1_tag;
               r_out  <= w_sum;
            end
         end
      end
      assign busy = r_s1_v | r_ov;
   end

   assign rsp_valid = {r_ov & r_otag, r_ov & ~r_otag};
   assign rsp_out   = r_out;
   assign gnt_cnt0  = r_cnt0;
   assign gnt_cnt1  = r_cnt1;

endmodule

// File: tb/tb_fma_mul_server.sv
// Randomised scoreboard bench: a LAT=2 instance and a LAT=1 / 3-bit-counter
// instance share one stimulus stream and are checked against a plain product model.
module tb_fma_mul_server;

   localparam int W = 27;

   typedef struct {
      bit          port;
      logic [53:0] prod;
      int          gcyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    req_valid;
   logic [W-1:0]  a0, b0, a1, b1;

   logic [1:0]    rdy1, rv1, rdy2, rv2;
   logic [53:0]   ro1, ro2;
   logic          busy1, busy2;
   logic [15:0]   c01, c11;
   logic [2:0]    c02, c12;

   exp_t          q1[$];
   exp_t          q2[$];
   int            checks = 0;
   int            passes = 0;
   int            cyc = 0;
   int            mc0 = 0;
   int            mc1 = 0;
   bit            mrr = 1'b0;
   logic [53:0]   last_p[2];

   fma_mul_server #(.W(W), .LAT(2), .CNTW(16)) u_dut1 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy1),
      .req_a0(a0), .req_b0(b0), .req_a1(a1), .req_b1(b1),
      .rsp_valid(rv1), .rsp_out(ro1), .busy(busy1),
      .gnt_cnt0(c01), .gnt_cnt1(c11)
   );

   fma_mul_server #(.W(W), .LAT(1), .CNTW(3)) u_dut2 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy2),
      .req_a0(a0), .req_b0(b0), .req_a1(a1), .req_b1(b1),
      .rsp_valid(rv2), .rsp_out(ro2), .busy(busy2),
      .gnt_cnt0(c02), .gnt_cnt1(c12)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act === exp)
         passes++;
      else
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
   endtask

   function automatic logic [63:0] sat(input int n, input logic [63:0] mx);
      return (64'(n) > mx) ? mx : 64'(n);
   endfunction

   task automatic mon(input int id, input int lat, input logic [1:0] rv,
                      input logic [53:0] ro, input logic bsy,
                      input logic [63:0] c0, input logic [63:0] c1,
                      input logic [63:0] cmax);
      exp_t e;
      bit   have;
      have = (id == 1) ? (q1.size() > 0) : (q2.size() > 0);
      chk($sformatf("busy%0d", id), 64'(bsy), 64'(have));
      chk($sformatf("gnt_cnt0_%0d", id), c0, sat(mc0, cmax));
      chk($sformatf("gnt_cnt1_%0d", id), c1, sat(mc1, cmax));
      if (rv != 2'b00) begin
         if (!have) begin
            chk($sformatf("unexpected_rsp%0d", id), 64'(rv), 64'(0));
         end else begin
            e = (id == 1) ? q1.pop_front() : q2.pop_front();
            chk($sformatf("rsp_tag%0d", id), 64'(rv),
                e.port ? 64'(2) : 64'(1));
            chk($sformatf("rsp_out%0d", id), 64'(ro), 64'(e.prod));
            chk($sformatf("latency%0d", id), 64'(cyc), 64'(e.gcyc + lat));
            last_p[id-1] = e.prod;
         end
      end else begin
         chk($sformatf("rsp_hold%0d", id), 64'(ro), 64'(last_p[id-1]));
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         mon(1, 2, rv1, ro1, busy1, 64'(c01), 64'(c11), 64'hFFFF);
         mon(2, 1, rv2, ro2, busy2, 64'(c02), 64'(c12), 64'h7);
      end
   end

   task automatic drive(input logic [1:0] v, input logic [W-1:0] x0,
                        input logic [W-1:0] y0, input logic [W-1:0] x1,
                        input logic [W-1:0] y1);
      logic [1:0] g;
      exp_t       e;
      @(negedge clk);
      req_valid = v;
      a0 = x0;
      b0 = y0;
      a1 = x1;
      b1 = y1;
      #1;
      if (v == 2'b11)
         g = mrr ? 2'b10 : 2'b01;
      else
         g = v;
      chk("req_ready1", 64'(rdy1), 64'(g));
      chk("req_ready2", 64'(rdy2), 64'(g));
      if (g != 2'b00) begin
         e.port = g[1];
         e.prod = e.port ? (54'(x1) * 54'(y1)) : (54'(x0) * 54'(y0));
         e.gcyc = cyc;
         q1.push_back(e);
         q2.push_back(e);
         if (e.port) mc1++;
         else        mc0++;
         mrr = ~e.port;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         drive(2'b00, '0, '0, '0, '0);
   endtask

   function automatic logic [W-1:0] rnd();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         default: return W'($urandom);
      endcase
   endfunction

   task automatic check_zero(input string tag);
      chk({tag, "_rv1"}, 64'(rv1), 64'(0));
      chk({tag, "_ro1"}, 64'(ro1), 64'(0));
      chk({tag, "_busy1"}, 64'(busy1), 64'(0));
      chk({tag, "_cnt1"}, 64'({c01, c11}), 64'(0));
      chk({tag, "_rv2"}, 64'(rv2), 64'(0));
      chk({tag, "_ro2"}, 64'(ro2), 64'(0));
      chk({tag, "_busy2"}, 64'(busy2), 64'(0));
      chk({tag, "_cnt2"}, 64'({c02, c12}), 64'(0));
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      reset = 1'b1;
      req_valid = 2'b00;
      #1;
      check_zero("async_rst");
      q1.delete();
      q2.delete();
      mc0 = 0;
      mc1 = 0;
      mrr = 1'b0;
      last_p[0] = '0;
      last_p[1] = '0;
      @(negedge clk);
      @(negedge clk);
      #2;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      req_valid = 2'b00;
      a0 = '0;
      b0 = '0;
      a1 = '0;
      b1 = '0;
      last_p[0] = '0;
      last_p[1] = '0;
      #1;
      check_zero("reset");
      @(negedge clk);
      #2;
      reset = 1'b0;

      drive(2'b01, 27'h800000, 27'h800000, '0, '0);
      idle(4);
      drive(2'b10, '0, '0, 27'hFFFFFF, 27'hFFFFFF);
      idle(3);
      for (int i = 0; i < 6; i++)
         drive(2'b11, rnd(), rnd(), rnd(), rnd());
      idle(3);
      drive(2'b01, 27'h7FFFFFF, 27'h7FFFFFF, rnd(), rnd());
      drive(2'b01, 27'h0, 27'h123456, rnd(), rnd());
      idle(3);

      for (int i = 0; i < 400; i++)
         drive(2'($urandom_range(0, 3)), rnd(), rnd(), rnd(), rnd());

      drive(2'b01, rnd(), rnd(), rnd(), rnd());
      drive(2'b10, rnd(), rnd(), rnd(), rnd());
      do_reset();
      idle(3);
      drive(2'b11, rnd(), rnd(), rnd(), rnd());
      drive(2'b11, rnd(), rnd(), rnd(), rnd());
      idle(3);

      for (int i = 0; i < 200; i++)
         drive(2'($urandom_range(0, 3)), rnd(), rnd(), rnd(), rnd());

      idle(4);
      chk("drain1", 64'(q1.size()), 64'(0));
      chk("drain2", 64'(q2.size()), 64'(0));
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
